riscv_crypto_fu_ssha_pipe: RTL and testbench

//  Parametrised, pipelined SHA-256/SHA-512 sigma/sum functional unit for the crypto FU.

---
 rtl/riscv_crypto_fu_ssha_pkg.sv | 39 +++
 rtl/riscv_crypto_fu_ssha_stage.sv | 36 +++
 rtl/riscv_crypto_fu_ssha_pipe.sv | 105 ++++++++++
 tb/tb_riscv_crypto_fu_ssha_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_crypto_fu_ssha_pkg.sv
// Op codes and bit helpers shared by the SHA-2 sigma/sum functional unit.
package riscv_crypto_fu_ssha_pkg;

  localparam logic [3:0] SSHA_OP_SHA256_SIG0  = 4'd0;
  localparam logic [3:0] SSHA_OP_SHA256_SIG1  = 4'd1;
  localparam logic [3:0] SSHA_OP_SHA256_SUM0  = 4'd2;
  localparam logic [3:0] SSHA_OP_SHA256_SUM1  = 4'd3;
  localparam logic [3:0] SSHA_OP_SHA512_SUM0R = 4'd4;
  localparam logic [3:0] SSHA_OP_SHA512_SUM1R = 4'd5;
  localparam logic [3:0] SSHA_OP_SHA512_SIG0L = 4'd6;
  localparam logic [3:0] SSHA_OP_SHA512_SIG0H = 4'd7;
  localparam logic [3:0] SSHA_OP_SHA512_SIG1L = 4'd8;
  localparam logic [3:0] SSHA_OP_SHA512_SIG1H = 4'd9;
  localparam logic [3:0] SSHA_OP_SHA512_SIG0  = 4'd10;
  localparam logic [3:0] SSHA_OP_SHA512_SIG1  = 4'd11;
  localparam logic [3:0] SSHA_OP_SHA512_SUM0  = 4'd12;
  localparam logic [3:0] SSHA_OP_SHA512_SUM1  = 4'd13;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] shr32(input logic [31:0] x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [63:0] shr64(input logic [63:0] x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/riscv_crypto_fu_ssha_stage.sv
// One valid/ready register slice of the sigma/sum result pipeline.
module riscv_crypto_fu_ssha_stage
  import riscv_crypto_fu_ssha_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         flush,
  input  logic         take,
  input  logic         up_valid,
  input  logic [W-1:0] up_rd,
  input  logic         up_err,
  output logic         valid,
  output logic [W-1:0] rd,
  output logic         err
);

  // Payload only moves on a real transfer; an empty slice keeps stale data.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      valid <= 1'b0;
      rd    <= '0;
      err   <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (take) begin
      valid <= up_valid;
      if (up_valid) begin
        rd  <= up_rd;
        err <= up_err;
      end
    end
  end

endmodule

// File: rtl/riscv_crypto_fu_ssha_pipe.sv
// Pipelined SHA-256/SHA-512 sigma/sum unit: inline combinational compute
// feeding PIPE_STAGES valid/ready register slices.
module riscv_crypto_fu_ssha_pipe
  import riscv_crypto_fu_ssha_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int PIPE_STAGES = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            out_err
);

  logic [31:0] a32, b32;
  logic [63:0] a64, res64;
  logic        cerr;
  logic        unused_bits;

  assign a32         = rs1[31:0];
  assign b32         = rs2[31:0];
  assign a64         = 64'(rs1);
  assign unused_bits = ^{rs2, res64};

  always_comb begin
    res64 = '0;
    cerr  = 1'b0;
    case (op)
      SSHA_OP_SHA256_SIG0:  res64 = sext32(ror32(a32, 7) ^ ror32(a32, 18) ^ shr32(a32, 3));
      SSHA_OP_SHA256_SIG1:  res64 = sext32(ror32(a32, 17) ^ ror32(a32, 19) ^ shr32(a32, 10));
      SSHA_OP_SHA256_SUM0:  res64 = sext32(ror32(a32, 2) ^ ror32(a32, 13) ^ ror32(a32, 22));
      SSHA_OP_SHA256_SUM1:  res64 = sext32(ror32(a32, 6) ^ ror32(a32, 11) ^ ror32(a32, 25));
      SSHA_OP_SHA512_SUM0R: res64 = {32'h0, (a32 << 25) ^ (a32 << 30) ^ (a32 >> 28) ^
                                            (b32 >> 7) ^ (b32 >> 2) ^ (b32 << 4)};
      SSHA_OP_SHA512_SUM1R: res64 = {32'h0, (a32 << 23) ^ (a32 >> 14) ^ (a32 >> 18) ^
                                            (b32 >> 9) ^ (b32 << 18) ^ (b32 << 14)};
      SSHA_OP_SHA512_SIG0L: res64 = {32'h0, (a32 >> 1) ^ (a32 >> 7) ^ (a32 >> 8) ^
                                            (b32 << 31) ^ (b32 << 25) ^ (b32 << 24)};
      SSHA_OP_SHA512_SIG0H: res64 = {32'h0, (a32 >> 1) ^ (a32 >> 7) ^ (a32 >> 8) ^
                                            (b32 << 31) ^ (b32 << 24)};
      SSHA_OP_SHA512_SIG1L: res64 = {32'h0, (a32 << 3) ^ (a32 >> 6) ^ (a32 >> 19) ^
                                            (b32 >> 29) ^ (b32 << 26) ^ (b32 << 13)};
      SSHA_OP_SHA512_SIG1H: res64 = {32'h0, (a32 << 3) ^ (a32 >> 6) ^ (a32 >> 19) ^
                                            (b32 >> 29) ^ (b32 << 13)};
      SSHA_OP_SHA512_SIG0:  res64 = ror64(a64, 1) ^ ror64(a64, 8) ^ shr64(a64, 7);
      SSHA_OP_SHA512_SIG1:  res64 = ror64(a64, 19) ^ ror64(a64, 61) ^ shr64(a64, 6);
      SSHA_OP_SHA512_SUM0:  res64 = ror64(a64, 28) ^ ror64(a64, 34) ^ ror64(a64, 39);
      SSHA_OP_SHA512_SUM1:  res64 = ror64(a64, 14) ^ ror64(a64, 18) ^ ror64(a64, 41);
      default:              cerr  = 1'b1;
    endcase
    // Split forms exist only on RV32, full 64-bit forms only on RV64.
    if ((op inside {[SSHA_OP_SHA512_SUM0R:SSHA_OP_SHA512_SIG1H]} && XLEN != 32) ||
        (op inside {[SSHA_OP_SHA512_SIG0:SSHA_OP_SHA512_SUM1]} && XLEN != 64))
      cerr = 1'b1;
    if (cerr) res64 = '0;
  end

  logic [PIPE_STAGES:0]   v, e;
  logic [XLEN-1:0]        d [PIPE_STAGES+1];
  logic [PIPE_STAGES-1:0] take;
  logic                   chain;

  assign v[0] = in_valid;
  assign e[0] = cerr;
  assign d[0] = res64[XLEN-1:0];

  // Ready ripples back from the consumer: a slice can take when empty or draining.
  always_comb begin
    chain = out_ready;
    take  = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      chain   = !v[k+1] | chain;
      take[k] = chain;
    end
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    riscv_crypto_fu_ssha_stage #(.W(XLEN)) u_stage (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .flush    (flush),
      .take     (take[k]),
      .up_valid (v[k]),
      .up_rd    (d[k]),
      .up_err   (e[k]),
      .valid    (v[k+1]),
      .rd       (d[k+1]),
      .err      (e[k+1])
    );
  end

  assign in_ready  = take[0];
  assign out_valid = v[PIPE_STAGES];
  assign rd        = d[PIPE_STAGES];
  assign out_err   = e[PIPE_STAGES];

endmodule

// File: tb/tb_riscv_crypto_fu_ssha_pipe.sv
// Bench for the sigma/sum unit: four instances (RV32/P1, RV64/P1, RV64/P3,
// RV32/P2) checked against a queue-based timing and arithmetic reference.
module tb_riscv_crypto_fu_ssha_pipe;

  localparam int N = 4;

  function automatic int xl_of(input int i);
    return (i == 0 || i == 3) ? 32 : 64;
  endfunction

  function automatic int ps_of(input int i);
    return (i == 2) ? 3 : (i == 3) ? 2 : 1;
  endfunction

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        in_valid [N];
  logic        flush [N];
  logic        out_ready [N];
  logic [3:0]  op [N];
  logic [63:0] rs1 [N];
  logic [63:0] rs2 [N];
  logic        in_ready [N];
  logic        out_valid [N];
  logic        out_err [N];
  logic [63:0] rd [N];

  always #5 g_clk = ~g_clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int XLG = xl_of(g);
    localparam int PSG = ps_of(g);
    logic           iy, ov, oe;
    logic [XLG-1:0] r;
    riscv_crypto_fu_ssha_pipe #(.XLEN(XLG), .PIPE_STAGES(PSG)) u_dut (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (iy),
      .op        (op[g]),
      .rs1       (rs1[g][XLG-1:0]),
      .rs2       (rs2[g][XLG-1:0]),
      .out_valid (ov),
      .out_ready (out_ready[g]),
      .rd        (r),
      .out_err   (oe)
    );
    assign in_ready[g]  = iy;
    assign out_valid[g] = ov;
    assign out_err[g]   = oe;
    assign rd[g]        = 64'(r);
  end

  int          checks, errors, cyc;
  logic [64:0] sb_val [N][256];
  int          sb_acc [N][256];
  int          wp [N];
  int          rp [N];
  logic        accepted [N];
  logic        emitted [N];

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] rot32(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  function automatic logic [63:0] rot64(input logic [63:0] x, input int n);
    logic [127:0] t;
    t = {x, x} >> n;
    return t[63:0];
  endfunction

  function automatic logic [63:0] big_sig0(input logic [63:0] x);
    return rot64(x, 1) ^ rot64(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] big_sig1(input logic [63:0] x);
    return rot64(x, 19) ^ rot64(x, 61) ^ (x >> 6);
  endfunction
  function automatic logic [63:0] big_sum0(input logic [63:0] x);
    return rot64(x, 28) ^ rot64(x, 34) ^ rot64(x, 39);
  endfunction
  function automatic logic [63:0] big_sum1(input logic [63:0] x);
    return rot64(x, 14) ^ rot64(x, 18) ^ rot64(x, 41);
  endfunction

  // RV32 split ops are halves of the 64-bit functions on {rs1,rs2} word pairs.
  function automatic logic [64:0] ref_fn(input int xl, input logic [3:0] o,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [31:0] w, s;
    logic [63:0] lo, hi, f;
    w  = a[31:0];
    lo = {b[31:0], a[31:0]};
    hi = {a[31:0], b[31:0]};
    s  = 32'h0;
    f  = 64'h0;
    case (o)
      4'd0: s = rot32(w, 7) ^ rot32(w, 18) ^ (w >> 3);
      4'd1: s = rot32(w, 17) ^ rot32(w, 19) ^ (w >> 10);
      4'd2: s = rot32(w, 2) ^ rot32(w, 13) ^ rot32(w, 22);
      4'd3: s = rot32(w, 6) ^ rot32(w, 11) ^ rot32(w, 25);
      default: s = 32'h0;
    endcase
    if (o <= 4'd3) return {1'b0, (xl == 64) ? {{32{s[31]}}, s} : {32'h0, s}};
    if (o >= 4'd4 && o <= 4'd9 && xl == 32) begin
      case (o)
        4'd4: begin f = big_sum0(lo); s = f[31:0]; end
        4'd5: begin f = big_sum1(lo); s = f[31:0]; end
        4'd6: begin f = big_sig0(lo); s = f[31:0]; end
        4'd7: begin f = big_sig0(hi); s = f[63:32]; end
        4'd8: begin f = big_sig1(lo); s = f[31:0]; end
        default: begin f = big_sig1(hi); s = f[63:32]; end
      endcase
      return {1'b0, 32'h0, s};
    end
    if (o >= 4'd10 && o <= 4'd13 && xl == 64) begin
      case (o)
        4'd10: f = big_sig0(a);
        4'd11: f = big_sig1(a);
        4'd12: f = big_sum0(a);
        default: f = big_sum1(a);
      endcase
      return {1'b0, f};
    end
    return {1'b1, 64'h0};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample mid-cycle against the model, update the model, cross the edge.
  // An op accepted at cycle c is due at the output from cycle c+PIPE_STAGES;
  // the oldest op never waits on anything ahead of it.
  task automatic step();
    logic exp_ir, exp_ov;
    int   cnt, hd;
    #4;
    for (int i = 0; i < N; i++) begin
      cnt    = wp[i] - rp[i];
      hd     = rp[i] % 256;
      exp_ir = !(cnt == ps_of(i) && !out_ready[i]);
      exp_ov = (cnt > 0) && (cyc >= sb_acc[i][hd] + ps_of(i));
      accepted[i] = in_valid[i] && in_ready[i];
      emitted[i]  = out_valid[i] && out_ready[i];
      if (!flush[i]) chk($sformatf("in_ready%0d", i), 65'(in_ready[i]), 65'(exp_ir));
      chk($sformatf("out_valid%0d", i), 65'(out_valid[i]), 65'(exp_ov));
      if (exp_ov) chk($sformatf("result%0d", i), {out_err[i], rd[i]}, sb_val[i][hd]);
      if (flush[i]) begin
        rp[i] = wp[i];
      end else begin
        if (exp_ov && out_ready[i]) rp[i]++;
        if (in_valid[i] && exp_ir) begin
          sb_val[i][wp[i] % 256] = ref_fn(xl_of(i), op[i], rs1[i], rs2[i]);
          sb_acc[i][wp[i] % 256] = cyc;
          wp[i]++;
        end
      end
    end
    @(posedge g_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0; flush[i] = 1'b0; out_ready[i] = 1'b1;
      op[i] = 4'd0; rs1[i] = 64'h0; rs2[i] = 64'h0;
    end
    @(posedge g_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_ov%0d", i), 65'(out_valid[i]), 65'(0));
      chk($sformatf("rst_rd%0d", i), {out_err[i], rd[i]}, 65'h0);
    end
    g_resetn = 1'b1;
    for (int i = 0; i < N; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
  endtask

  task automatic directed(input int i, input string tag, input logic [3:0] o,
                          input logic [63:0] a, input logic [63:0] b, input logic [64:0] exp);
    in_valid[i] = 1'b1; op[i] = o; rs1[i] = a; rs2[i] = b;
    step();
    in_valid[i] = 1'b0;
    repeat (ps_of(i) - 1) step();
    chk({tag, "_ov"}, 65'(out_valid[i]), 65'(1));
    chk(tag, {out_err[i], rd[i]}, exp);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_out, sent;
    checks = 0; errors = 0; cyc = 0;
    do_reset();

    // Known-answer vectors
    directed(0, "s256_sig0_32",  4'd0,  64'h1, 64'h0, {1'b0, 64'h0000_0000_0200_4000});
    directed(0, "s256_sum1_32",  4'd3,  64'h1, 64'h0, {1'b0, 64'h0000_0000_0420_0080});
    directed(0, "sig0l_32",      4'd6,  64'h0, 64'h1, {1'b0, 64'h0000_0000_8300_0000});
    directed(0, "sig0h_32",      4'd7,  64'h0, 64'h1, {1'b0, 64'h0000_0000_8100_0000});
    directed(0, "rv64op_on_32",  4'd10, 64'h1, 64'h0, {1'b1, 64'h0});
    directed(0, "undef_on_32",   4'd15, 64'h1, 64'h1, {1'b1, 64'h0});
    directed(1, "sig0_64",       4'd10, 64'h1, 64'h0, {1'b0, 64'h8100_0000_0000_0000});
    directed(1, "s256_sext_64",  4'd0,  64'hFFFF_FFFF_0000_0040, 64'h0,
             {1'b0, 64'hFFFF_FFFF_8010_0008});
    directed(1, "sum0r_on_64",   4'd4,  64'h1234, 64'h5678, {1'b1, 64'h0});
    directed(1, "undef_on_64",   4'd15, 64'h1, 64'h1, {1'b1, 64'h0});
    directed(2, "sum1_64_p3",    4'd13, 64'h1, 64'h0, {1'b0, 64'h0004_4000_0000_0000 | 64'h0000_0000_0080_0000});

    // Fill the 3-deep pipe under back-pressure, then release it
    out_ready[2] = 1'b0; in_valid[2] = 1'b1;
    op[2] = 4'($urandom_range(0, 13)); rs1[2] = {$urandom, $urandom};
    n_acc = 0; n_out = 0; sent = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (accepted[2]) begin
        n_acc++; sent++;
        op[2] = 4'($urandom_range(0, 13)); rs1[2] = {$urandom, $urandom};
      end
    end
    chk("stall_accepts", 65'(n_acc), 65'(3));
    out_ready[2] = 1'b1;
    for (int k = 0; k < 30 && (sent < 5 || wp[2] != rp[2]); k++) begin
      if (sent >= 5) in_valid[2] = 1'b0;
      step();
      if (emitted[2]) n_out++;
      if (accepted[2]) begin
        sent++;
        op[2] = 4'($urandom_range(0, 13)); rs1[2] = {$urandom, $urandom};
      end
    end
    in_valid[2] = 1'b0;
    chk("stall_emitted", 65'(n_out), 65'(5));
    chk("stall_drained", 65'(out_valid[2]), 65'(0));

    // Flush with two ops in flight and a new request in the same cycle
    out_ready[3] = 1'b0; in_valid[3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      op[3] = 4'($urandom_range(0, 9)); rs1[3] = {32'h0, $urandom}; rs2[3] = {32'h0, $urandom};
      step();
    end
    flush[3] = 1'b1; op[3] = 4'd1;
    step();
    flush[3] = 1'b0; in_valid[3] = 1'b0;
    chk("flush_ov", 65'(out_valid[3]), 65'(0));
    chk("flush_ir", 65'(in_ready[3]), 65'(1));
    out_ready[3] = 1'b1; n_out = 0;
    repeat (4) begin
      step();
      if (emitted[3]) n_out++;
    end
    chk("flush_dropped", 65'(n_out), 65'(0));

    // Random traffic on all instances
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        out_ready[i] = ($urandom_range(0, 3) != 0);
        flush[i]     = ($urandom_range(0, 31) == 0);
        op[i]        = 4'($urandom_range(0, 15));
        rs1[i]       = {$urandom, $urandom};
        rs2[i]       = {$urandom, $urandom};
      end
      step();
    end

    // Async reset while stalled drops everything at once
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b1; out_ready[i] = 1'b0; flush[i] = 1'b0;
    end
    repeat (4) step();
    #2;
    g_resetn = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("async_ov%0d", i), 65'(out_valid[i]), 65'(0));
      chk($sformatf("async_rd%0d", i), {out_err[i], rd[i]}, 65'h0);
    end
    do_reset();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
